// File: rtl/plinko_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plinko_pkg
//  Description : Shared types and ASCII constants for the Plinko histogram
//                streamer: FSM state encoding, character codes and the
//                "Count" row label.
//  Revision    : 1.0 - initial release
// ============================================================================
package plinko_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LABEL = 3'd1,
        ST_BAR   = 3'd2,
        ST_EOL   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] CH_PIPE  = 8'h7C;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_NL    = 8'h0A;
    localparam logic [7:0] CH_EQ    = 8'h3D;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    // Row label "Count"
    localparam logic [7:0] CH_C = 8'h43;
    localparam logic [7:0] CH_O = 8'h6F;
    localparam logic [7:0] CH_U = 8'h75;
    localparam logic [7:0] CH_N = 8'h6E;
    localparam logic [7:0] CH_T = 8'h74;

    // Index of the last label byte (13 bytes: 0..12)
    localparam logic [3:0] LABEL_LAST = 4'd12;

    // Character of the "Count" word at label position 0..4
    function automatic logic [7:0] label_word_char(input logic [3:0] idx);
        case (idx)
            4'd0:    return CH_C;
            4'd1:    return CH_O;
            4'd2:    return CH_U;
            4'd3:    return CH_N;
            4'd4:    return CH_T;
            default: return CH_SP;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/plinko_dec2ascii.sv
`default_nettype none
// ============================================================================
//  Module      : plinko_dec2ascii
//  Description : Combinational conversion of a 6-bit value (0..63) into two
//                ASCII decimal digits.
//  Ports       : val_i  - value to convert
//                tens_o - ASCII tens digit
//                ones_o - ASCII ones digit
//  Revision    : 1.0 - initial release
// ============================================================================
module plinko_dec2ascii
    import plinko_pkg::*;
(
    input  logic [5:0] val_i,
    output logic [7:0] tens_o,
    output logic [7:0] ones_o
);

    logic [5:0] w_tens;
    logic [5:0] w_ones;

    // Constant divisor; synthesises to a small lookup/adder network
    assign w_tens = val_i / 6'd10;
    assign w_ones = val_i % 6'd10;

    assign tens_o = CH_ZERO + {2'b00, w_tens};
    assign ones_o = CH_ZERO + {2'b00, w_ones};

endmodule
`default_nettype wire

// File: rtl/plinko_bar_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : plinko_bar_streamer
//  Description : Serialises a snapshot of the Plinko bin counters as an ASCII
//                histogram ("CountN = dd: | | ...\n" per bin) over a
//                valid/ready byte stream.
//  Ports       : clk        - rising-edge clock
//                rst        - synchronous active-low reset
//                start      - dump request (ignored while busy)
//                counts     - packed bin counts, bin 1 in the LSBs
//                char_data  - ASCII output byte
//                char_valid - char_data valid
//                char_ready - sink accepts the byte
//                busy       - dump in progress
//                done       - one-cycle pulse after the last byte is accepted
//  Revision    : 1.0 - initial release
// ============================================================================
module plinko_bar_streamer
    import plinko_pkg::*;
#(
    parameter int NUM_BINS = 8,
    parameter int COUNT_W  = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_BINS*COUNT_W-1:0] counts,
    output logic [7:0]                  char_data,
    output logic                        char_valid,
    input  logic                        char_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

    state_t               state_q;
    logic [COUNT_W-1:0]   snap_q [NUM_BINS];
    logic [3:0]           lbl_idx_q;
    logic [COUNT_W-1:0]   bar_cnt_q;
    logic                 phase_q;     // 0: '|' next, 1: ' ' next
    logic [BIN_W-1:0]     bin_q;
    logic                 fin_q;       // final '\n' loaded, awaiting acceptance
    logic [7:0]           data_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 done_q;

    logic [COUNT_W-1:0]   cur_cnt;
    logic [7:0]           tens_ch;
    logic [7:0]           ones_ch;
    logic [7:0]           byte_d;
    logic                 load_d;

    plinko_dec2ascii u_dec (
        .val_i  (6'(cur_cnt)),
        .tens_o (tens_ch),
        .ones_o (ones_ch)
    );

    // Byte at the current generator position, and whether the output
    // register can take it this cycle (empty, or being drained right now).
    always_comb begin
        cur_cnt = snap_q[bin_q];
        byte_d  = 8'h00;
        load_d  = 1'b0;
        case (state_q)
            ST_LABEL: begin
                case (lbl_idx_q)
                    4'd5:    byte_d = CH_ZERO + 8'd1 + {{(8-BIN_W){1'b0}}, bin_q};
                    4'd6:    byte_d = CH_SP;
                    4'd7:    byte_d = CH_EQ;
                    4'd8:    byte_d = CH_SP;
                    4'd9:    byte_d = tens_ch;
                    4'd10:   byte_d = ones_ch;
                    4'd11:   byte_d = CH_COLON;
                    4'd12:   byte_d = CH_SP;
                    default: byte_d = label_word_char(lbl_idx_q);
                endcase
            end
            ST_BAR:  byte_d = phase_q ? CH_SP : CH_PIPE;
            ST_EOL:  byte_d = CH_NL;
            default: byte_d = 8'h00;
        endcase
        if ((state_q == ST_LABEL) || (state_q == ST_BAR) ||
            ((state_q == ST_EOL) && !fin_q)) begin
            load_d = !valid_q || char_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < NUM_BINS; i++) snap_q[i] <= '0;
            lbl_idx_q <= '0;
            bar_cnt_q <= '0;
            phase_q   <= 1'b0;
            bin_q     <= '0;
            fin_q     <= 1'b0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (valid_q && char_ready) valid_q <= 1'b0;
            if (load_d) begin
                data_q  <= byte_d;
                valid_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < NUM_BINS; i++)
                            snap_q[i] <= counts[i*COUNT_W +: COUNT_W];
                        bin_q     <= '0;
                        lbl_idx_q <= '0;
                        fin_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_LABEL;
                    end
                end
                ST_LABEL: begin
                    if (load_d) begin
                        if (lbl_idx_q == LABEL_LAST) begin
                            lbl_idx_q <= '0;
                            bar_cnt_q <= '0;
                            phase_q   <= 1'b0;
                            state_q   <= (cur_cnt == '0) ? ST_EOL : ST_BAR;
                        end else begin
                            lbl_idx_q <= lbl_idx_q + 4'd1;
                        end
                    end
                end
                ST_BAR: begin
                    if (load_d) begin
                        if (phase_q) begin
                            phase_q <= 1'b0;
                            if (bar_cnt_q == cur_cnt - COUNT_W'(1))
                                state_q <= ST_EOL;
                            else
                                bar_cnt_q <= bar_cnt_q + COUNT_W'(1);
                        end else begin
                            phase_q <= 1'b1;
                        end
                    end
                end
                ST_EOL: begin
                    if (load_d) begin
                        if (bin_q == BIN_W'(NUM_BINS - 1)) begin
                            fin_q <= 1'b1;
                        end else begin
                            bin_q   <= bin_q + BIN_W'(1);
                            state_q <= ST_LABEL;
                        end
                    end
                    // Final '\n' accepted: pulse done in the following cycle
                    if (fin_q && valid_q && char_ready) begin
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign char_data  = data_q;
    assign char_valid = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_plinko_bar_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plinko_bar_streamer
//  Description : Scoreboard bench for plinko_bar_streamer. Expected dumps are
//                built from formatted strings and queued at start; a monitor
//                pops and compares every accepted byte, checks handshake
//                stability and the done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plinko_bar_streamer;

    localparam int NB = 8;
    localparam int CW = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [NB*CW-1:0] counts = '0;
    logic [7:0]     char_data;
    logic           char_valid;
    logic           char_ready = 1'b0;
    logic           busy;
    logic           done;

    plinko_bar_streamer #(.NUM_BINS(NB), .COUNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .counts     (counts),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    logic [7:0] exp_q [$];
    int  exp_len      = 0;
    int  bytes_dump   = 0;
    bit  dump_pending = 0;
    bit  expect_done  = 0;
    bit  dump_done_seen = 0;
    int  ready_mode   = 0;   // 0: always 1, 1: random, 2: always 0

    // Reference model: the whole dump as text
    task automatic push_expected(input logic [NB*CW-1:0] cv);
        string s;
        int    v;
        exp_len = 0;
        for (int b = 0; b < NB; b++) begin
            v = int'(cv[b*CW +: CW]);
            s = $sformatf("Count%0d = %02d: ", b + 1, v);
            for (int k = 0; k < v; k++) s = {s, "| "};
            s = {s, "\n"};
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
            exp_len += 14 + 2 * v;
        end
    endtask

    // Sink ready generator
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       char_ready = 1'b1;
            1:       char_ready = 1'($urandom_range(0, 1));
            default: char_ready = 1'b0;
        endcase
    end

    // Monitor / scoreboard
    bit         prev_ok = 0;
    bit         prev_valid = 0;
    bit         prev_ready = 0;
    logic [7:0] prev_data = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            if (expect_done || done) begin
                n_vec++;
                if (!(expect_done && done && !busy && bytes_dump == exp_len)) begin
                    n_fail++;
                    $display("FAIL done_pulse: done=%0b busy=%0b bytes=%0d, required done=%0b busy=0 bytes=%0d",
                             done, busy, bytes_dump, expect_done, exp_len);
                end
                if (expect_done) dump_done_seen = 1;
                expect_done = 0;
            end
            if (prev_ok && prev_valid && !prev_ready) begin
                n_vec++;
                if (!(char_valid && char_data == prev_data)) begin
                    n_fail++;
                    $display("FAIL hold_stable: valid=%0b data=%02h, required valid=1 data=%02h",
                             char_valid, char_data, prev_data);
                end
            end
            if (char_valid && char_ready) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL extra_byte: data=%02h, required no byte", char_data);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    bytes_dump++;
                    if (char_data !== e) begin
                        n_fail++;
                        $display("FAIL byte[%0d]: data=%02h, required %02h", bytes_dump - 1, char_data, e);
                    end
                    if (exp_q.size() == 0 && dump_pending) begin
                        expect_done  = 1;
                        dump_pending = 0;
                    end
                end
            end
        end
        prev_ok    = rst;
        prev_valid = char_valid;
        prev_ready = char_ready;
        prev_data  = char_data;
    end

    task automatic check(input string name, input bit ok, input int act, input int req);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!dump_done_seen && cyc < 4000) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        check("dump_timeout", dump_done_seen, cyc, 0);
    endtask

    task automatic start_dump(input logic [NB*CW-1:0] cv, input int rmode, input bit check_lat);
        push_expected(cv);
        bytes_dump     = 0;
        dump_pending   = 1;
        dump_done_seen = 0;
        @(posedge clk); #1;
        ready_mode = rmode;
        counts     = cv;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (check_lat) begin
            check("lat_cycle1", busy && !char_valid, {busy, char_valid}, 2'b10);
            @(posedge clk); #1;
            check("lat_cycle2", char_valid && char_data == 8'h43, {char_valid, char_data}, 9'h143);
        end
    endtask

    function automatic logic [NB*CW-1:0] all_bins(input int v);
        logic [NB*CW-1:0] r;
        for (int b = 0; b < NB; b++) r[b*CW +: CW] = CW'(v);
        return r;
    endfunction

    logic [NB*CW-1:0] cv;
    logic [63:0]      rnd;

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", !char_valid && !busy && !done && char_data == 8'h00,
              {char_valid, busy, done, char_data}, 0);
        rst = 1'b1;

        // All zeros, ready held high, with latency check
        start_dump('0, 0, 1);
        wait_done();

        // Only bin 3 = 5
        cv = '0; cv[2*CW +: CW] = CW'(5);
        start_dump(cv, 0, 0);
        wait_done();

        // All bins at max
        start_dump(all_bins(31), 0, 1);
        wait_done();

        // Counts 1..8, random ready
        for (int b = 0; b < NB; b++) cv[b*CW +: CW] = CW'(b + 1);
        start_dump(cv, 1, 0);
        wait_done();

        // Random counts, random ready; one with start and counts disturbed
        for (int t = 0; t < 4; t++) begin
            rnd = {$urandom(), $urandom()};
            cv  = rnd[NB*CW-1:0];
            start_dump(cv, (t == 0) ? 0 : 1, 0);
            if (t == 1) begin
                repeat (25) @(posedge clk);
                #1;
                rnd    = {$urandom(), $urandom()};
                counts = rnd[NB*CW-1:0];
                start  = 1'b1;
                @(posedge clk); #1;
                start  = 1'b0;
                rnd    = {$urandom(), $urandom()};
                counts = rnd[NB*CW-1:0];
            end
            wait_done();
        end

        // Reset during bin 4 bar (bins of 5: bar of bin 4 spans bytes 85..94)
        start_dump(all_bins(5), 0, 0);
        begin
            int cyc = 0;
            while (bytes_dump < 86 && cyc < 1000) begin
                @(posedge clk); #1;
                cyc++;
            end
            check("reach_bar4", bytes_dump >= 86, bytes_dump, 86);
        end
        ready_mode = 2;
        @(posedge clk); #2;
        rst = 1'b0;
        exp_q.delete();
        dump_pending = 0;
        expect_done  = 0;
        @(posedge clk); #1;
        check("mid_reset", !char_valid && !busy && !done, {char_valid, busy, done}, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("reset_no_done", !done && !busy, {done, busy}, 0);
        end
        rst = 1'b1;
        start_dump(all_bins(2), 1, 1);
        wait_done();

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plinko_bar_streamer.md
Name: plinko_bar_streamer

Overview:
- Reads the eight bin counters produced by plinkoboard and serialises them as an ASCII histogram, one byte per accepted handshake.
- Each row has the form "Count<n> = <dd>: " followed by one "| " per ball, then '\n'.
- Sits downstream of plinkoboard and feeds a UART or console sink over a valid/ready byte interface.
- Counts are snapshotted when a dump starts, so the board may keep counting while the dump runs.

Parameters:
- NUM_BINS, 8: number of bins (rows), legal range 1..9 so the row index is one ASCII digit.
- COUNT_W, 5: width of each bin count, legal range 1..6 so the value fits in two decimal digits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  single-cycle request to begin a dump; ignored while busy=1.
- counts  in  NUM_BINS*COUNT_W  packed bin counts; bin 1 occupies bits [COUNT_W-1:0].
- char_data  out  8  ASCII byte.
- char_valid  out  1  char_data is valid.
- char_ready  in  1  sink accepts the byte on the cycle with char_valid & char_ready.
- busy  out  1  a dump is in progress.
- done  out  1  one-cycle pulse after the final '\n' is accepted.

Behaviour:
- Reset (rst=0 at a clk edge):
  - State goes to IDLE.
  - char_valid=0, busy=0, done=0, char_data=8'h00.
  - The snapshot and all indices are cleared.
  - This applies mid-dump: the partial row is abandoned and no done pulse is issued.
- IDLE:
  - On start=1, latch counts into the snapshot, set bin=0 and busy=1 on the next cycle, and enter LABEL.
- LABEL emits 13 bytes in order: 'C','o','u','n','t', ('1'+bin), ' ', '=', ' ', tens, ones, ':', ' '.
  - tens = '0' + value/10 and ones = '0' + value%10.
  - The value is zero-extended to 6 bits before conversion.
- BAR:
  - Emits '|' then ' ', repeated snapshot[bin] times.
  - A count of 0 skips BAR entirely and goes straight to EOL.
- EOL:
  - Emits '\n'.
  - If bin < NUM_BINS-1: bin increments and the block returns to LABEL.
  - Otherwise the block enters DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE.
  - A start seen in the DONE cycle is ignored.
- Handshake rules:
  - The byte pointer advances only on char_valid & char_ready.
  - While char_valid=1 and char_ready=0, char_data and char_valid hold stable.
  - char_valid never drops without acceptance, except on reset.
  - char_valid does not depend combinationally on char_ready.
- Throughput and latency:
  - One byte per cycle is sustained when char_ready is held at 1.
  - The first byte is valid on the second cycle after the start cycle.
- Row length is 14 + 2*count bytes. The total dump length is the sum of the row lengths.
- Changes on counts after the start cycle have no effect on an in-progress dump.

Decomposition:
- Shared package plinko_pkg holds:
  - The state encoding: IDLE, LABEL, BAR, EOL, DONE.
  - ASCII constants: CH_PIPE=8'h7C, CH_SP=8'h20, CH_NL=8'h0A, CH_EQ=8'h3D, CH_COLON=8'h3A, CH_ZERO=8'h30.
  - The label string "Count" as constants.
- Sub-module plinko_dec2ascii (combinational): 6-bit value in, two ASCII digits out (tens, ones).
- The streamer contains the FSM, a 4-bit label index, a COUNT_W-bit bar counter, a 1-bit pipe/space phase, and the bin index.

Test Plan:
- All counts 0, char_ready=1, pulse start:
  - 112 bytes are produced; row 1 is "Count1 = 00: \n" and row 8 is "Count8 = 00: \n".
  - done pulses once, in the cycle after the final '\n' is accepted.
- counts = {bin3=5, others 0}:
  - Row 3 is "Count3 = 05: | | | | | \n" (24 bytes); total is 122 bytes.
- counts all 31:
  - Each row is "CountN = 31: " followed by 31 "| " pairs and '\n' (76 bytes per row, 608 in total).
  - The digits '3' (8'h33) and '1' (8'h31) appear in the tens/ones positions.
- Random char_ready (about 50% duty) with counts 1..8 in bins 1..8:
  - The byte stream is identical to the char_ready=1 run; there are no drops or duplicates.
  - char_data is stable whenever char_valid & !char_ready.
- Robustness checks:
  - start asserted again mid-dump: ignored.
  - counts changed mid-dump: output matches the snapshot.
  - rst=0 during BAR of bin 4: the next cycle shows char_valid=0, busy=0, with no done pulse.
  - A new start after reset begins again at "Count1".
